// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bundle between the PS/2 FIFO, the decoder and the host.
// PS2_LOCK_STATE_EN adds the lock_state output.
interface ps2_scancode_decoder_if;
    logic [7:0] byte_in;
    logic       byte_parity_err;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_release;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] modifiers;
    logic       status_ack;
    logic       status_resend;
    logic       status_bat;
    logic       error_sticky;
    logic       error_clear;
`ifdef PS2_LOCK_STATE_EN
    logic [2:0] lock_state;
`endif

    modport slave (
        input  byte_in, byte_parity_err, byte_valid,
        input  event_ready, error_clear,
        output byte_ready, event_code, event_extended,
        output event_release, event_valid, modifiers,
        output status_ack, status_resend, status_bat,
        output error_sticky
`ifdef PS2_LOCK_STATE_EN
        , output lock_state
`endif
    );

    modport master (
        output byte_in, byte_parity_err, byte_valid,
        output event_ready, error_clear,
        input  byte_ready, event_code, event_extended,
        input  event_release, event_valid, modifiers,
        input  status_ack, status_resend, status_bat,
        input  error_sticky
`ifdef PS2_LOCK_STATE_EN
        , input lock_state
`endif
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Scan code set 2 prefix parser: E0/F0/E1 sequences -> key events, modifiers.
// Optional lock-key tracking when PS2_LOCK_STATE_EN is defined.
module ps2_scancode_decoder #(
    parameter int CLKS_PER_US       = 82,
    parameter int PREFIX_TIMEOUT_US = 2000
) (
    input logic                    main_clk,
    input logic                    main_reset,
    ps2_scancode_decoder_if.slave  bus
);

    localparam int DW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        PAUSE
    } state_t;

    state_t     state;
    state_t     nxt;
    logic [2:0] pcnt;
    logic [2:0] pcnt_nxt;
    logic [DW-1:0] div_cnt;
    logic [11:0]   to_cnt;
    logic       us_tick;
    logic       timeout;

    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;
    logic [7:0] mods;
    logic       ack_q;
    logic       resend_q;
    logic       bat_q;
    logic       err_q;

    logic       xfer;
    logic       emit;
    logic [7:0] e_code;
    logic       e_ext;
    logic       e_rel;
    logic       set_err;
    logic       ack_set;
    logic       resend_set;
    logic       bat_set;
    logic [7:0] mask;

    function automatic logic [7:0] mod_mask(logic [7:0] code, logic ext);
        logic [7:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                8'h12:   m = 8'h01;
                8'h59:   m = 8'h02;
                8'h14:   m = 8'h04;
                8'h11:   m = 8'h10;
                default: m = '0;
            endcase
        end else begin
            case (code)
                8'h14:   m = 8'h08;
                8'h11:   m = 8'h20;
                8'h1F:   m = 8'h40;
                8'h27:   m = 8'h80;
                default: m = '0;
            endcase
        end
        return m;
    endfunction

    assign bus.byte_ready = !ev_valid || bus.event_ready;
    assign xfer    = bus.byte_valid && bus.byte_ready;
    assign us_tick = (div_cnt == DW'(CLKS_PER_US - 1));
    assign timeout = (state != IDLE) && !xfer
                  && (to_cnt == 12'(PREFIX_TIMEOUT_US));

    always_comb begin
        nxt        = state;
        pcnt_nxt   = pcnt;
        emit       = 1'b0;
        e_code     = bus.byte_in;
        e_ext      = 1'b0;
        e_rel      = 1'b0;
        set_err    = 1'b0;
        ack_set    = 1'b0;
        resend_set = 1'b0;
        bat_set    = 1'b0;
        if (xfer && bus.byte_parity_err) begin
            nxt     = IDLE;
            set_err = 1'b1;
        end else if (xfer) begin
            unique case (state)
                IDLE: begin
                    case (bus.byte_in)
                        8'hE0: nxt = EXT;
                        8'hF0: nxt = BRK;
                        8'hE1: begin
                            nxt      = PAUSE;
                            pcnt_nxt = 3'd1;
                        end
                        8'hFA: ack_set    = 1'b1;
                        8'hFE: resend_set = 1'b1;
                        8'hAA: bat_set    = 1'b1;
                        8'h00, 8'hFF, 8'hFC: set_err = 1'b1;
                        default: emit = 1'b1;
                    endcase
                end
                EXT: begin
                    nxt = IDLE;
                    if (bus.byte_in == 8'hF0) begin
                        nxt = EXT_BRK;
                    end else if (bus.byte_in != 8'h12 &&
                                 bus.byte_in != 8'h59) begin
                        emit  = 1'b1;
                        e_ext = 1'b1;
                    end
                end
                BRK: begin
                    nxt   = IDLE;
                    emit  = 1'b1;
                    e_rel = 1'b1;
                end
                EXT_BRK: begin
                    nxt = IDLE;
                    // PrintScreen wraps itself in fake shift codes
                    if (bus.byte_in != 8'h12 && bus.byte_in != 8'h59) begin
                        emit  = 1'b1;
                        e_ext = 1'b1;
                        e_rel = 1'b1;
                    end
                end
                PAUSE: begin
                    if (pcnt == 3'd7) begin
                        nxt    = IDLE;
                        emit   = 1'b1;
                        e_code = 8'hE1;
                    end else begin
                        pcnt_nxt = pcnt + 3'd1;
                    end
                end
                default: nxt = IDLE;
            endcase
        end else if (timeout) begin
            nxt     = IDLE;
            set_err = 1'b1;
        end
    end

    assign mask = mod_mask(e_code, e_ext);

`ifdef PS2_LOCK_STATE_EN
    logic [2:0] lock_q;
    logic [2:0] held;
    logic [2:0] lkey;

    always_comb begin
        lkey = '0;
        if (!e_ext) begin
            case (e_code)
                8'h58:   lkey = 3'b001;
                8'h77:   lkey = 3'b010;
                8'h7E:   lkey = 3'b100;
                default: lkey = '0;
            endcase
        end
    end

    // Typematic repeats of a held lock key must not toggle it again
    always_ff @(posedge main_clk) begin
        if (main_reset) begin
            lock_q <= '0;
            held   <= '0;
        end else if (emit && e_rel) begin
            held <= held & ~lkey;
        end else if (emit) begin
            held   <= held | lkey;
            lock_q <= lock_q ^ (lkey & ~held);
        end
    end

    assign bus.lock_state = lock_q;
`endif

    always_ff @(posedge main_clk) begin
        if (main_reset) begin
            state    <= IDLE;
            pcnt     <= '0;
            div_cnt  <= '0;
            to_cnt   <= '0;
            ev_valid <= 1'b0;
            ev_code  <= '0;
            ev_ext   <= 1'b0;
            ev_rel   <= 1'b0;
            mods     <= '0;
            ack_q    <= 1'b0;
            resend_q <= 1'b0;
            bat_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= nxt;
            pcnt     <= pcnt_nxt;
            ack_q    <= ack_set;
            resend_q <= resend_set;
            bat_q    <= bat_set;
            div_cnt  <= us_tick ? '0 : div_cnt + DW'(1);

            if (state == IDLE || xfer || timeout) begin
                to_cnt <= '0;
            end else if (us_tick) begin
                to_cnt <= to_cnt + 12'd1;
            end

            if (emit) begin
                ev_valid <= 1'b1;
                ev_code  <= e_code;
                ev_ext   <= e_ext;
                ev_rel   <= e_rel;
                mods     <= e_rel ? (mods & ~mask) : (mods | mask);
            end else if (bus.event_ready) begin
                ev_valid <= 1'b0;
            end

            if (set_err) begin
                err_q <= 1'b1;
            end else if (bus.error_clear) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.event_code     = ev_code;
    assign bus.event_extended = ev_ext;
    assign bus.event_release  = ev_rel;
    assign bus.event_valid    = ev_valid;
    assign bus.modifiers      = mods;
    assign bus.status_ack     = ack_q;
    assign bus.status_resend  = resend_q;
    assign bus.status_bat     = bat_q;
    assign bus.error_sticky   = err_q;

endmodule
